// File: rtl/mem_responder.sv
// CPU-facing memory request responder: decodes single-word requests to the DDR2
// user port or the IO register space, with a command timeout and sticky error flags.
module mem_responder #(
  parameter int          TIMEOUT  = 1023,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memory_read_req,
  input  logic        memory_write_req,
  input  logic [25:0] memory_addr,
  input  logic [31:0] memory_data_write,
  output logic [31:0] memory_data_read,
  output logic        memory_busy,
  output logic [24:0] ddr_addr,
  output logic        ddr_read,
  output logic        ddr_write,
  output logic [31:0] ddr_wdata,
  input  logic        ddr_ready,
  input  logic [31:0] ddr_rdata,
  input  logic        ddr_rdata_valid,
  output logic [7:0]  io_addr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        err_clear,
  output logic        err_timeout,
  output logic        err_overrun
);

  typedef enum logic [2:0] {IDLE, IO_ACC, DDR_CMD, DDR_WAIT, DONE} state_t;

  // Last cycle on which a DDR request may still complete before it is aborted.
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [24:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [9:0]  tmo_cnt;
  logic        req, accept, overrun, tmo_hit, tmo_set;
  logic        data_load;
  logic [31:0] data_nxt;

  assign req     = memory_read_req | memory_write_req;
  assign accept  = (state == IDLE) && req;
  assign overrun = (state != IDLE) && req;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    data_load = 1'b0;
    data_nxt  = memory_data_read;
    tmo_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = memory_addr[25] ? IO_ACC : DDR_CMD;
      end
      IO_ACC: begin
        state_nxt = DONE;
        if (!wr_q) begin
          data_load = 1'b1;
          data_nxt  = io_rdata;
        end
      end
      DDR_CMD: begin
        if (ddr_ready) begin
          if (wr_q) begin
            state_nxt = DONE;
          end else if (ddr_rdata_valid) begin
            data_load = 1'b1;
            data_nxt  = ddr_rdata;
            state_nxt = DONE;
          end else begin
            state_nxt = DDR_WAIT;
          end
        end else if (tmo_hit) begin
          tmo_set   = 1'b1;
          state_nxt = DONE;
          if (!wr_q) begin
            data_load = 1'b1;
            data_nxt  = ERR_WORD;
          end
        end
      end
      DDR_WAIT: begin
        if (ddr_rdata_valid) begin
          data_load = 1'b1;
          data_nxt  = ddr_rdata;
          state_nxt = DONE;
        end else if (tmo_hit) begin
          tmo_set   = 1'b1;
          data_load = 1'b1;
          data_nxt  = ERR_WORD;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      wr_q             <= 1'b0;
      tmo_cnt          <= '0;
      memory_busy      <= 1'b0;
      memory_data_read <= '0;
      err_timeout      <= 1'b0;
      err_overrun      <= 1'b0;
    end else begin
      state       <= state_nxt;
      memory_busy <= (state_nxt != IDLE);
      if (accept) begin
        addr_q  <= memory_addr[24:0];
        wdata_q <= memory_data_write;
        wr_q    <= memory_write_req;
        tmo_cnt <= '0;
      end else if (state == DDR_CMD || state == DDR_WAIT) begin
        tmo_cnt <= tmo_cnt + 10'd1;
      end
      if (data_load) memory_data_read <= data_nxt;
      // A set event in the same cycle as err_clear keeps the flag set.
      if (tmo_set)        err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
      if (overrun)        err_overrun <= 1'b1;
      else if (err_clear) err_overrun <= 1'b0;
    end
  end

  assign ddr_read  = (state == DDR_CMD) && !wr_q;
  assign ddr_write = (state == DDR_CMD) && wr_q;
  assign io_rd     = (state == IO_ACC) && !wr_q;
  assign io_wr     = (state == IO_ACC) && wr_q;
  assign ddr_addr  = addr_q;
  assign io_addr   = addr_q[7:0];
  assign ddr_wdata = wdata_q;
  assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: per-transaction timeline model checked every cycle.
module tb_mem_responder;
  localparam int TIMEOUT = 1023;

  logic        clk;
  logic        reset_n;
  logic        memory_read_req, memory_write_req;
  logic [25:0] memory_addr;
  logic [31:0] memory_data_write, memory_data_read;
  logic        memory_busy;
  logic [24:0] ddr_addr;
  logic        ddr_read, ddr_write;
  logic [31:0] ddr_wdata;
  logic        ddr_ready;
  logic [31:0] ddr_rdata;
  logic        ddr_rdata_valid;
  logic [7:0]  io_addr;
  logic        io_rd, io_wr;
  logic [31:0] io_wdata, io_rdata;
  logic        err_clear, err_timeout, err_overrun;

  mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .memory_read_req(memory_read_req), .memory_write_req(memory_write_req),
    .memory_addr(memory_addr), .memory_data_write(memory_data_write),
    .memory_data_read(memory_data_read), .memory_busy(memory_busy),
    .ddr_addr(ddr_addr), .ddr_read(ddr_read), .ddr_write(ddr_write),
    .ddr_wdata(ddr_wdata), .ddr_ready(ddr_ready), .ddr_rdata(ddr_rdata),
    .ddr_rdata_valid(ddr_rdata_valid), .io_addr(io_addr), .io_rd(io_rd),
    .io_wr(io_wr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .err_clear(err_clear), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // expected outputs for the current cycle
  logic        e_busy, e_drd, e_dwr, e_iord, e_iowr, e_et, e_eo;
  logic [31:0] e_data, e_wdata;
  logic [25:0] e_addr;
  logic        chk_en;
  // effects that become visible one cycle later
  logic        p_set_t, p_set_o, p_clr, p_load;
  logic [31:0] p_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(memory_busy), 32'(e_busy));
      chk("data_read", memory_data_read, e_data);
      chk("ddr_read", 32'(ddr_read), 32'(e_drd));
      chk("ddr_write", 32'(ddr_write), 32'(e_dwr));
      chk("io_rd", 32'(io_rd), 32'(e_iord));
      chk("io_wr", 32'(io_wr), 32'(e_iowr));
      chk("err_timeout", 32'(err_timeout), 32'(e_et));
      chk("err_overrun", 32'(err_overrun), 32'(e_eo));
      if (e_drd || e_dwr) chk("ddr_addr", 32'(ddr_addr), 32'(e_addr[24:0]));
      if (e_dwr) chk("ddr_wdata", ddr_wdata, e_wdata);
      if (e_iord || e_iowr) chk("io_addr", 32'(io_addr), 32'(e_addr[7:0]));
      if (e_iowr) chk("io_wdata", io_wdata, e_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (p_clr) begin e_et = 1'b0; e_eo = 1'b0; end
    if (p_set_t) e_et = 1'b1;
    if (p_set_o) e_eo = 1'b1;
    if (p_load) e_data = p_val;
    p_clr = 1'b0; p_set_t = 1'b0; p_set_o = 1'b0; p_load = 1'b0;
  endtask

  task automatic io_op(input logic [25:0] a, input logic [31:0] wd, input bit wr,
                       input logic [31:0] rd);
    tick();
    memory_addr = a; memory_data_write = wd;
    memory_write_req = wr; memory_read_req = !wr;
    tick();
    memory_write_req = 1'b0; memory_read_req = 1'b0;
    e_addr = a; e_wdata = wd; e_busy = 1'b1; e_iowr = wr; e_iord = !wr;
    io_rdata = rd;
    tick();
    e_iowr = 1'b0; e_iord = 1'b0;
    if (!wr) e_data = rd;
    io_rdata = 32'h0BADBAD0;
    tick();
    e_busy = 1'b0;
  endtask

  // ready_at / valid_at / overrun_at / clr_at are cycle indices counted from the
  // first cycle the DDR command is presented; out-of-range values mean "never".
  task automatic ddr_op(input logic [25:0] a, input logic [31:0] wd, input bit wr,
                        input bit both, input int ready_at, input int valid_at,
                        input logic [31:0] rd, input int overrun_at, input int clr_at);
    bit acc, fin, done;
    acc = 0; done = 0;
    tick();
    memory_addr = a; memory_data_write = wd;
    memory_write_req = wr; memory_read_req = !wr || both;
    for (int k = 0; k < 1100; k++) begin
      tick();
      memory_write_req = 1'b0; memory_read_req = 1'b0; err_clear = 1'b0;
      e_busy = 1'b1; e_addr = a; e_wdata = wd;
      e_drd = !acc && !wr; e_dwr = !acc && wr;
      ddr_ready = !acc && (k >= ready_at);
      ddr_rdata_valid = (k == valid_at);
      ddr_rdata = (k == valid_at) ? rd : (32'h0BAD0000 | 32'(k));
      if (k == overrun_at) begin memory_read_req = 1'b1; p_set_o = 1'b1; end
      if (k == clr_at) begin err_clear = 1'b1; p_clr = 1'b1; end
      fin = 0;
      if (!acc && k >= ready_at) begin
        acc = 1;
        if (wr) fin = 1;
        else if (k == valid_at) begin p_load = 1'b1; p_val = rd; fin = 1; end
      end else if (acc && k == valid_at) begin
        p_load = 1'b1; p_val = rd; fin = 1;
      end
      if (!fin && k == TIMEOUT - 1) begin
        fin = 1; p_set_t = 1'b1;
        if (!wr) begin p_load = 1'b1; p_val = 32'hDEADBEEF; end
      end
      if (fin) begin done = 1; break; end
    end
    if (!done) chk("ddr_bound", 32'd0, 32'd1);
    tick();
    memory_read_req = 1'b0; err_clear = 1'b0;
    ddr_ready = 1'b0; ddr_rdata_valid = 1'b0;
    e_drd = 1'b0; e_dwr = 1'b0; e_busy = 1'b1;
    tick();
    e_busy = 1'b0;
  endtask

  task automatic zero_exp();
    e_busy = 0; e_drd = 0; e_dwr = 0; e_iord = 0; e_iowr = 0; e_et = 0; e_eo = 0;
    e_data = '0; e_wdata = '0; e_addr = '0;
    p_set_t = 0; p_set_o = 0; p_clr = 0; p_load = 0; p_val = '0;
  endtask

  initial begin
    chk_en = 1'b0;
    zero_exp();
    reset_n = 1'b1;
    memory_read_req = 0; memory_write_req = 0; memory_addr = '0; memory_data_write = '0;
    ddr_ready = 0; ddr_rdata = '0; ddr_rdata_valid = 0; io_rdata = '0; err_clear = 0;
    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // IO write then read
    io_op(26'h2000005, 32'h12345678, 1'b1, 32'h0);
    io_op(26'h2000005, 32'h0, 1'b0, 32'hCAFEF00D);
    chk("io_read_data", memory_data_read, 32'hCAFEF00D);

    // DDR read: ready low 3 cycles, data 5 cycles after acceptance
    ddr_op(26'h0000100, 32'h0, 1'b0, 1'b0, 3, 8, 32'hA5A5A5A5, -1, -1);
    chk("ddr_read_data", memory_data_read, 32'hA5A5A5A5);
    chk("ddr_read_busy_low", 32'(memory_busy), 32'd0);

    // DDR read with data in the acceptance cycle; DDR write leaves data alone
    ddr_op(26'h0000ABC, 32'h0, 1'b0, 1'b0, 1, 1, 32'h11223344, -1, -1);
    chk("ddr_fast_read", memory_data_read, 32'h11223344);
    ddr_op(26'h1FFFFFF, 32'h77665544, 1'b1, 1'b0, 0, -1, 32'h0, -1, -1);
    chk("write_keeps_data", memory_data_read, 32'h11223344);

    // DDR read timeout
    ddr_op(26'h0000200, 32'h0, 1'b0, 1'b0, 5000, 5000, 32'h0, -1, -1);
    chk("timeout_data", memory_data_read, 32'hDEADBEEF);
    chk("timeout_flag", 32'(err_timeout), 32'd1);
    // stray data strobe while idle
    tick();
    ddr_rdata_valid = 1'b1; ddr_rdata = 32'h99999999;
    tick();
    ddr_rdata_valid = 1'b0;
    tick();
    chk("stray_valid_ignored", memory_data_read, 32'hDEADBEEF);
    err_clear = 1'b1; p_clr = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("timeout_cleared", 32'(err_timeout), 32'd0);

    // overrun during a DDR write, with err_clear in the same cycle
    ddr_op(26'h0000300, 32'h55AA55AA, 1'b1, 1'b0, 3, -1, 32'h0, 1, 1);
    chk("overrun_flag", 32'(err_overrun), 32'd1);
    chk("overrun_no_timeout", 32'(err_timeout), 32'd0);

    // simultaneous read+write pulse is a write
    ddr_op(26'h0000400, 32'h0F0F0F0F, 1'b1, 1'b1, 0, -1, 32'h0, -1, -1);
    chk("priority_keeps_data", memory_data_read, 32'hDEADBEEF);

    // reset while waiting for DDR read data
    tick();
    memory_addr = 26'h0000500; memory_read_req = 1'b1;
    tick();
    memory_read_req = 1'b0; e_busy = 1'b1; e_drd = 1'b1; e_addr = 26'h0000500;
    ddr_ready = 1'b1;
    tick();
    ddr_ready = 1'b0; e_drd = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    zero_exp();
    #1;
    chk("rst_ddr_read", 32'(ddr_read), 32'd0);
    chk("rst_busy", 32'(memory_busy), 32'd0);
    chk("rst_data", memory_data_read, 32'd0);
    chk("rst_err_overrun", 32'(err_overrun), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    io_op(26'h2000010, 32'h0, 1'b0, 32'h0BADF00D);
    chk("post_reset_io_read", memory_data_read, 32'h0BADF00D);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
